// File: rtl/mult_pkg.sv
// Shared definitions for the 2x2 multiplier lab: product width, largest
// product value and the accumulator's state encoding.
package mult_pkg;

    localparam int PROD_W   = 4;
    localparam int MAX_PROD = 9;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } acc_state_e;

endpackage : mult_pkg

// File: rtl/mult_product_accumulator.sv
// Sums N_TERMS consecutive products from the 2x2 multiplier and holds the
// result, with a sticky carry flag, until the consumer takes it.
module mult_product_accumulator
    import mult_pkg::*;
#(
    parameter int ACC_W   = 8,
    parameter int N_TERMS = 4,
    parameter int CNT_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf,
    output logic [CNT_W-1:0]  term_cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    acc_state_e         state_r;
    logic [ACC_W-1:0]   sum_r;
    logic               ovf_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [ACC_W:0]     sum_ext_s;
    logic               carry_s;

    // Single widened adder; its top bit is the carry out of the accumulator.
    always_comb begin
        sum_ext_s = {1'b0, sum_r} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
        carry_s   = sum_ext_s[ACC_W];
    end

    // Accumulation and handoff state machine; reset and clear share one path.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_r <= ST_ACC;
            sum_r   <= {ACC_W{1'b0}};
            ovf_r   <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_ACC: begin
                    if (in_valid) begin
                        sum_r <= sum_ext_s[ACC_W-1:0];
                        ovf_r <= ovf_r | carry_s;
                        cnt_r <= cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
                        if (cnt_r == LAST_CNT) begin
                            state_r <= ST_HOLD;
                        end else begin
                            state_r <= ST_ACC;
                        end
                    end else begin
                        state_r <= ST_ACC;
                    end
                end
                ST_HOLD: begin
                    // Handoff restarts the sum; nothing is accepted this cycle.
                    if (out_ready) begin
                        state_r <= ST_ACC;
                        sum_r   <= {ACC_W{1'b0}};
                        ovf_r   <= 1'b0;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r <= ST_ACC;
                    sum_r   <= {ACC_W{1'b0}};
                    ovf_r   <= 1'b0;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = (state_r == ST_ACC);
    assign out_valid = (state_r == ST_HOLD);
    assign sum       = sum_r;
    assign ovf       = ovf_r;
    assign term_cnt  = cnt_r;

endmodule : mult_product_accumulator

// File: tb/tb_mult_product_accumulator.sv
// Directed bench: default 8-bit accumulator plus a 5-bit instance sharing the
// same stimulus so the wrap/overflow case can be observed.
module tb_mult_product_accumulator;

    logic       clk = 1'b0;
    logic       rst_n, clear, in_valid, out_ready;
    logic [3:0] prod;

    logic       in_ready, out_valid, ovf;
    logic [7:0] sum;
    logic [2:0] term_cnt;

    logic       in_ready5, out_valid5, ovf5;
    logic [4:0] sum5;
    logic [2:0] term_cnt5;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mult_product_accumulator dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready), .prod(prod), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .ovf(ovf), .term_cnt(term_cnt)
    );

    mult_product_accumulator #(.ACC_W(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready5), .prod(prod), .out_valid(out_valid5),
        .out_ready(out_ready), .sum(sum5), .ovf(ovf5), .term_cnt(term_cnt5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [3:0] p);
        in_valid = 1'b1;
        prod     = p;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b1; prod = 4'd9; out_ready = 1'b0;

        // Reset with a product offered: nothing counted.
        tick(); tick();
        chk("rst_sum", sum, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_term_cnt", term_cnt, 0);
        chk("rst_in_ready", in_ready, 1);

        // 9,9,9,9 back to back.
        rst_n = 1'b1;
        in_valid = 1'b1; prod = 4'd9;
        tick(); tick(); tick();
        chk("b2b_sum3", sum, 27);
        chk("b2b_cnt3", term_cnt, 3);
        chk("b2b_ov3", out_valid, 0);
        tick();
        chk("b2b_out_valid", out_valid, 1);
        chk("b2b_sum", sum, 36);
        chk("b2b_ovf", ovf, 0);
        chk("b2b_cnt", term_cnt, 4);
        chk("b2b_in_ready", in_ready, 0);
        chk("w5_sum", sum5, 4);
        chk("w5_ovf", ovf5, 1);
        chk("w5_out_valid", out_valid5, 1);

        // Hold five cycles while a product is still offered.
        prod = 4'd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_sum", sum, 36);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_cnt", term_cnt, 4);
            chk("hold_out_valid", out_valid, 1);
        end

        // Handoff with in_valid still high: no pass-through.
        out_ready = 1'b1; prod = 4'd9;
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        chk("ho_sum", sum, 0);
        chk("ho_out_valid", out_valid, 0);
        chk("ho_in_ready", in_ready, 1);
        chk("ho_cnt", term_cnt, 0);
        chk("w5_ho_ovf", ovf5, 0);
        chk("w5_ho_sum", sum5, 0);

        // Products 1,0,4,6 with idle cycles; garbage on prod while idle.
        offer(4'd1);
        prod = 4'd15; tick();
        chk("gap_sum1", sum, 1);
        chk("gap_cnt1", term_cnt, 1);
        offer(4'd0); prod = 4'd15; tick();
        offer(4'd4); prod = 4'd15; tick(); tick();
        chk("gap_ov3", out_valid, 0);
        offer(4'd6);
        chk("gap_sum", sum, 11);
        chk("gap_out_valid", out_valid, 1);
        chk("gap_cnt", term_cnt, 4);
        out_ready = 1'b1;
        tick();
        chk("gap_ho_sum", sum, 0);
        chk("gap_ho_in_ready", in_ready, 1);
        chk("gap_ho_out_valid", out_valid, 0);
        tick();
        chk("gap_once", out_valid, 0);
        out_ready = 1'b0;

        // Clear mid-result discards partial sum and the offered product.
        offer(4'd6); offer(4'd4);
        chk("clr_pre_sum", sum, 10);
        clear = 1'b1; in_valid = 1'b1; prod = 4'd9;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_sum", sum, 0);
        chk("clr_cnt", term_cnt, 0);
        chk("clr_out_valid", out_valid, 0);
        offer(4'd1); offer(4'd2); offer(4'd3); offer(4'd4);
        chk("clr_new_sum", sum, 10);
        chk("clr_new_ov", out_valid, 1);
        chk("clr_new_ovf", ovf, 0);

        // Reset in HOLD together with out_ready: no second result.
        rst_n = 1'b0; out_ready = 1'b1;
        tick();
        chk("mrst_sum", sum, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();
        chk("mrst_once", out_valid, 0);
        out_ready = 1'b0;

        // Clear wins over handoff in HOLD.
        offer(4'd2); offer(4'd2); offer(4'd2); offer(4'd2);
        chk("chold_sum", sum, 8);
        chk("chold_ov", out_valid, 1);
        clear = 1'b1; out_ready = 1'b1;
        tick();
        clear = 1'b0; out_ready = 1'b0;
        chk("chold_clr_sum", sum, 0);
        chk("chold_clr_ov", out_valid, 0);
        chk("chold_clr_ir", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mult_product_accumulator
